// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity, 1 or 2 stop bits.
// Reports parity, framing, break and overrun status and hands words out with valid/ready.
module uart_rx_cfg #(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != 0);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic                 sync1_q;
  logic                 rx_s_q;
  logic                 rx_prev_q;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 ferr_q;
  logic                 all_low_q;
  logic                 stop_cnt_q;

  logic start_edge_c;
  logic half_hit_c;
  logic last_hit_c;
  logic can_load_c;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_pin;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign start_edge_c = rx_prev_q & ~rx_s_q;
  assign half_hit_c   = (cnt_q == CNT_HALF);
  assign last_hit_c   = (cnt_q == CNT_LAST);
  assign can_load_c   = ~rx_data_valid | rx_data_ready;

  // Frame FSM with the output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      ferr_q        <= 1'b0;
      all_low_q     <= 1'b0;
      stop_cnt_q    <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      // Handshake first; a load later in this block overrides the valid clear
      if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
        rx_overrun    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_edge_c) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end

        S_START: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (half_hit_c && rx_s_q) begin
            state_q <= S_IDLE;
          end else if (last_hit_c) begin
            state_q    <= S_DATA;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            all_low_q  <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end

        S_DATA: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (half_hit_c) begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (rx_s_q) all_low_q <= 1'b0;
          end
          if (last_hit_c) begin
            cnt_q     <= '0;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) state_q <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (half_hit_c) begin
            par_err_q <= (((^shift_q) ^ rx_s_q) != PAR_ODD);
            if (rx_s_q) all_low_q <= 1'b0;
          end
          if (last_hit_c) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (half_hit_c) begin
            if (stop_cnt_q == STOP_LAST) begin
              // Final stop sample: leave early so a back-to-back start edge is caught
              state_q <= S_IDLE;
              if (can_load_c) begin
                rx_data       <= shift_q;
                rx_parity_err <= par_err_q;
                rx_frame_err  <= ferr_q | ~rx_s_q;
                rx_break      <= all_low_q & ~rx_s_q;
                rx_data_valid <= 1'b1;
              end else begin
                rx_overrun    <= 1'b1;
              end
            end else begin
              ferr_q <= ferr_q | ~rx_s_q;
              if (rx_s_q) all_low_q <= 1'b0;
            end
          end
          if (last_hit_c) begin
            cnt_q      <= '0;
            stop_cnt_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
